demux_1_8_bit_sequencer: RTL and testbench

- Upstream feeder for the 1:8 DEMUX.
- Accepts one byte per frame over a valid/ready handshake.
- Serialises the byte into eight single-bit transfers, driving the DEMUX Enable, Data and Select inputs so that bit i is routed to DEMUX output i.
- Supports optional idle gaps between bits and reports frame completion.

---
 rtl/demux_1_8_bit_sequencer.sv | 112 +++++++++++
 tb/tb_demux_1_8_bit_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_8_bit_sequencer.sv
// Serialises one byte per frame into eight Enable/Data/Select transfers for a 1:8 DEMUX,
// with optional idle gaps between bits and a one-cycle frame-done pulse.
module demux_1_8_bit_sequencer #(
    parameter int GAP_CYCLES = 0,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic       Clock_In,
    input  logic       Reset_In,
    input  logic       Byte_Valid_In,
    input  logic [7:0] Byte_In,
    output logic       Byte_Ready_Out,
    output logic       Enable_Out,
    output logic       Data_Out,
    output logic [2:0] Select_Out,
    output logic       Busy_Out,
    output logic       Frame_Done_Out
);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    localparam logic [2:0] FIRST_IDX = LSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [2:0] LAST_IDX  = LSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] gap_q, gap_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] nxt_idx;
    logic       en_q, en_d;
    logic       data_q, data_d;
    logic       done_q, done_d;

    // Select_Out doubles as the bit counter; it still holds the last index during GAP.
    assign nxt_idx = LSB_FIRST ? sel_q + 3'd1 : sel_q - 3'd1;

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            byte_q  <= '0;
            gap_q   <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            data_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        sel_d   = sel_q;
        en_d    = 1'b0;
        data_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d = 3'd0;
                if (Byte_Valid_In) begin
                    state_d = DRIVE;
                    byte_d  = Byte_In;
                    sel_d   = FIRST_IDX;
                    en_d    = 1'b1;
                    data_d  = Byte_In[FIRST_IDX];
                end
            end
            DRIVE: begin
                if (sel_q == LAST_IDX) begin
                    state_d = IDLE;
                    sel_d   = 3'd0;
                    done_d  = 1'b1;
                end else if (GAP_CYCLES == 0) begin
                    sel_d  = nxt_idx;
                    en_d   = 1'b1;
                    data_d = byte_q[nxt_idx];
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_q <= 8'd1) begin
                    state_d = DRIVE;
                    gap_d   = 8'd0;
                    sel_d   = nxt_idx;
                    en_d    = 1'b1;
                    data_d  = byte_q[nxt_idx];
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Byte_Ready_Out = (state_q == IDLE);
    assign Busy_Out       = (state_q == DRIVE) || (state_q == GAP);
    assign Enable_Out     = en_q;
    assign Data_Out       = data_q;
    assign Select_Out     = sel_q;
    assign Frame_Done_Out = done_q;

endmodule

// File: tb/tb_demux_1_8_bit_sequencer.sv
// Bench for demux_1_8_bit_sequencer: one LSB-first/no-gap instance and one MSB-first/gap-2
// instance, checked cycle by cycle against a per-frame expected output list.
module tb_demux_1_8_bit_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       va, vb;
    logic [7:0] ba, bb;
    logic       ra, ea, da, busya, donea;
    logic [2:0] sa;
    logic       rb, eb, db, busyb, doneb;
    logic [2:0] sb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    demux_1_8_bit_sequencer #(.GAP_CYCLES(0), .LSB_FIRST(1'b1)) dut_a (
        .Clock_In(clk), .Reset_In(rst), .Byte_Valid_In(va), .Byte_In(ba),
        .Byte_Ready_Out(ra), .Enable_Out(ea), .Data_Out(da), .Select_Out(sa),
        .Busy_Out(busya), .Frame_Done_Out(donea));

    demux_1_8_bit_sequencer #(.GAP_CYCLES(2), .LSB_FIRST(1'b0)) dut_b (
        .Clock_In(clk), .Reset_In(rst), .Byte_Valid_In(vb), .Byte_In(bb),
        .Byte_Ready_Out(rb), .Enable_Out(eb), .Data_Out(db), .Select_Out(sb),
        .Busy_Out(busyb), .Frame_Done_Out(doneb));

    // Observed tuple: {busy, enable, select[2:0], data, done, ready}
    function automatic logic [7:0] obs(input int d);
        return (d == 0) ? {busya, ea, sa, da, donea, ra} : {busyb, eb, sb, db, doneb, rb};
    endfunction

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic drive(input int d, input logic v, input logic [7:0] b);
        if (d == 0) begin va = v; ba = b; end
        else begin vb = v; bb = b; end
    endtask

    task automatic idle_cycles(input int d, input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (obs(d) !== 8'b0000_0001) begin
                n_fail++;
                $display("FAIL %s idle cycle %0d: got %b expected %b", name, i, obs(d), 8'b0000_0001);
            end
        end
    endtask

    // Offers byte b in the current (idle or done) cycle and checks the whole frame up to and
    // including its done cycle. noisy keeps valid high with Byte_In = 0x00 while busy; chain
    // keeps valid high with nb so it is taken in the done cycle.
    task automatic run_frame(input int d, input logic [7:0] b, input bit noisy,
                             input bit chain, input logic [7:0] nb, input string name);
        logic [7:0] exp_q[$];
        logic [7:0] got, recon;
        int busy_n, en_n, idx, g;
        g = gap_of(d);
        for (int k = 0; k < 8; k++) begin
            idx = (d == 0) ? k : 7 - k;
            exp_q.push_back({1'b1, 1'b1, 3'(idx), b[idx], 1'b0, 1'b0});
            if (k < 7)
                for (int j = 0; j < g; j++) exp_q.push_back({1'b1, 1'b0, 3'(idx), 1'b0, 1'b0, 1'b0});
        end
        exp_q.push_back(8'b0000_0011);
        drive(d, 1'b1, b);
        recon = 8'h00; busy_n = 0; en_n = 0;
        for (int j = 0; j < exp_q.size(); j++) begin
            @(posedge clk); #1;
            got = obs(d);
            n_tests++;
            if (got !== exp_q[j]) begin
                n_fail++;
                $display("FAIL %s byte=%h cycle %0d: got %b expected %b", name, b, j, got, exp_q[j]);
            end
            if (got[7]) busy_n++;
            if (got[6]) begin en_n++; recon[got[5:3]] = got[2]; end
            if (j == 0) begin
                if (chain) drive(d, 1'b1, nb);
                else if (noisy) drive(d, 1'b1, 8'h00);
                else drive(d, 1'b0, 8'h00);
            end
            if (j == exp_q.size() - 1) begin
                if (chain) drive(d, 1'b1, nb);
                else drive(d, 1'b0, 8'h00);
            end
        end
        n_tests++;
        if (busy_n != 8 + 7 * g) begin
            n_fail++;
            $display("FAIL %s busy_len byte=%h: got %0d expected %0d", name, b, busy_n, 8 + 7 * g);
        end
        n_tests++;
        if (en_n != 8 || recon !== b) begin
            n_fail++;
            $display("FAIL %s demux_outputs: got %h (%0d enables) expected %h (8 enables)", name, recon, en_n, b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                n_tests++;
                if (obs(d) !== 8'b0000_0001) begin
                    n_fail++;
                    $display("FAIL reset dut%0d cycle %0d: got %b expected %b", d, i, obs(d), 8'b0000_0001);
                end
            end
        end
    endtask

    task automatic test_lsb_gap0();
        run_frame(0, 8'hA5, 1'b0, 1'b0, 8'h00, "lsb_gap0");
        for (int i = 0; i < 6; i++) begin
            idle_cycles(0, $urandom_range(0, 2), "lsb_gap0");
            run_frame(0, 8'($urandom), 1'b0, 1'b0, 8'h00, "lsb_gap0_rand");
        end
    endtask

    task automatic test_msb_gap2();
        run_frame(1, 8'h3C, 1'b0, 1'b0, 8'h00, "msb_gap2");
        for (int i = 0; i < 4; i++) begin
            idle_cycles(1, $urandom_range(0, 2), "msb_gap2");
            run_frame(1, 8'($urandom), 1'b0, 1'b0, 8'h00, "msb_gap2_rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        idle_cycles(0, 1, "b2b");
        run_frame(0, 8'hFF, 1'b0, 1'b1, 8'h01, "b2b_first");
        run_frame(0, 8'h01, 1'b0, 1'b0, 8'h00, "b2b_second");
        r = 8'($urandom);
        run_frame(1, 8'($urandom), 1'b0, 1'b1, r, "b2b_gap_first");
        run_frame(1, r, 1'b0, 1'b0, 8'h00, "b2b_gap_second");
    endtask

    task automatic test_byte_change();
        idle_cycles(0, 1, "byte_change");
        run_frame(0, 8'hF0, 1'b1, 1'b0, 8'h00, "byte_change_a");
        idle_cycles(1, 1, "byte_change");
        run_frame(1, 8'hF0, 1'b1, 1'b0, 8'h00, "byte_change_b");
    endtask

    task automatic test_reset_mid();
        logic [7:0] b, exp;
        b = 8'hAA;
        idle_cycles(0, 2, "reset_mid");
        drive(0, 1'b1, b);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 0) drive(0, 1'b0, 8'h00);
            exp = {1'b1, 1'b1, 3'(k), b[k], 1'b0, 1'b0};
            n_tests++;
            if (obs(0) !== exp) begin
                n_fail++;
                $display("FAIL reset_mid pre bit %0d: got %b expected %b", k, obs(0), exp);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (obs(0) !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL reset_mid immediate: got %b expected %b", obs(0), 8'b0000_0001);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (obs(0) !== 8'b0000_0001) begin
                n_fail++;
                $display("FAIL reset_mid held cycle %0d: got %b expected %b", i, obs(0), 8'b0000_0001);
            end
        end
        rst = 1'b0;
        idle_cycles(0, 2, "reset_mid_after");
        run_frame(0, 8'h0F, 1'b0, 1'b0, 8'h00, "reset_mid_recover");
    endtask

    initial begin
        test_reset();
        test_lsb_gap0();
        test_msb_gap2();
        test_back_to_back();
        test_byte_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
